eth_tx_framebuf: RTL and testbench

//  Transmit-side frame buffer for the Ethernet MAC; mirrors the byte-in/word-out RX buffer in the opposite direction.
//  CPU writes a frame as 64-bit words with byte enables, then writes tx_len/tx_start.
//  A reader FSM streams the frame byte-by-byte to the MAC TX path over valid/ready, padding short frames to 60 bytes.

---
 rtl/eth_tx_pkg.sv | 14 +
 rtl/eth_tx_dpram.sv | 46 ++++
 rtl/eth_tx_framebuf.sv | 213 +++++++++++++++++++++
 tb/tb_eth_tx_framebuf.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared constants and FSM state type for the Ethernet transmit frame buffer.
package eth_tx_pkg;

  // Shortest frame (without FCS) handed to the MAC; shorter frames are zero-padded.
  localparam int MIN_FRAME_LEN = 60;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } tx_state_e;

endpackage

// File: rtl/eth_tx_dpram.sv
// True dual-port word RAM: port A is the CPU (byte-enabled read/write),
// port B is the transmit reader (read-only). Both reads have one cycle of
// latency and hold their output until the next read on that port.
module eth_tx_dpram #(
  parameter int WORD_AW = 8
) (
  input  logic               clk,
  input  logic               a_en_i,
  input  logic [7:0]         a_we_i,
  input  logic [WORD_AW-1:0] a_addr_i,
  input  logic [63:0]        a_wdata_i,
  output logic [63:0]        a_rdata_o,
  input  logic               b_en_i,
  input  logic [WORD_AW-1:0] b_addr_i,
  output logic [63:0]        b_rdata_o
);

  logic [63:0] mem [2**WORD_AW];
  logic [63:0] a_rdata_q;
  logic [63:0] b_rdata_q;

  // Port A: per-lane writes, or a registered read when no lane is enabled.
  always_ff @(posedge clk) begin
    if (a_en_i) begin
      for (int k = 0; k < 8; k++) begin
        if (a_we_i[k]) begin
          mem[a_addr_i][8*k +: 8] <= a_wdata_i[8*k +: 8];
        end
      end
      if (a_we_i == 8'h00) begin
        a_rdata_q <= mem[a_addr_i];
      end
    end
  end

  // Port B: registered read for the frame reader.
  always_ff @(posedge clk) begin
    if (b_en_i) begin
      b_rdata_q <= mem[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/eth_tx_framebuf.sv
// Transmit frame buffer: the CPU loads a frame as 64-bit words, then a reader
// streams it byte by byte (lane 0 first) to the MAC over valid/ready, padding
// short frames with zero bytes up to the minimum frame length.
module eth_tx_framebuf
  import eth_tx_pkg::*;
#(
  parameter int WORD_AW = 8,
  parameter int LEN_W   = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_en,
  input  logic [7:0]         cpu_we,
  input  logic [WORD_AW-1:0] cpu_addr,
  input  logic [63:0]        cpu_wdata,
  output logic [63:0]        cpu_rdata,
  input  logic               tx_start,
  input  logic [LEN_W-1:0]   tx_len,
  output logic               tx_busy,
  output logic               tx_done,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last
);

  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_FRAME_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W:0]   SEVEN   = (LEN_W+1)'(7);
  localparam logic [LEN_W-3:0] FW_ONE  = (LEN_W-2)'(1);

  tx_state_e          state_q;
  logic               tx_busy_q;
  logic               tx_done_q;
  logic               tx_valid_q;
  logic               tx_last_q;
  logic [7:0]         tx_data_q;
  logic [LEN_W-1:0]   len_q;      // requested length (pad boundary)
  logic [LEN_W-1:0]   flen_q;     // bytes actually sent, at least MIN_L
  logic [LEN_W-1:0]   ld_idx_q;   // index of next byte to load into the output register
  logic [LEN_W-3:0]   fw_q;       // next word index to fetch
  logic [LEN_W-3:0]   nw_q;       // number of words covering flen_q
  logic               rd_pend_q;  // RAM port B data arrives this cycle
  logic [1:0]         cnt_q;      // occupied entries in the word buffer
  logic [63:0]        w0_q;
  logic [63:0]        w1_q;

  logic [63:0]        ram_rdata;
  logic [WORD_AW-1:0] rd_addr;
  logic               rd_fire;
  logic               start_ok;
  logic               start_zero;
  logic [LEN_W-1:0]   flen_start;
  logic [LEN_W-3:0]   nw_start;
  logic               streaming;
  logic               head_ok;
  logic [63:0]        head_w;
  logic               load;
  logic               pop;
  logic               push;
  logic               accept;
  logic               fin;
  logic [7:0]         byte_d;
  logic               last_d;
  logic [1:0]         cnt_d;
  logic [63:0]        w0_d;
  logic [63:0]        w1_d;

  eth_tx_dpram #(
    .WORD_AW (WORD_AW)
  ) u_ram (
    .clk       (clk),
    .a_en_i    (cpu_en),
    .a_we_i    (cpu_we),
    .a_addr_i  (cpu_addr),
    .a_wdata_i (cpu_wdata),
    .a_rdata_o (cpu_rdata),
    .b_en_i    (rd_fire),
    .b_addr_i  (rd_addr),
    .b_rdata_o (ram_rdata)
  );

  // Start decode, fetch scheduling and output-byte selection.
  always_comb begin
    start_ok   = (state_q == IDLE) && tx_start && (tx_len != '0);
    start_zero = (state_q == IDLE) && tx_start && (tx_len == '0);
    flen_start = (tx_len < MIN_L) ? MIN_L : tx_len;
    nw_start   = (LEN_W-2)'(({1'b0, flen_start} + SEVEN) >> 3);
    streaming  = (state_q == FETCH) || (state_q == SEND);
    // The word just returned by the RAM can be used directly when the buffer is empty.
    head_ok    = (cnt_q != 2'd0) || rd_pend_q;
    head_w     = (cnt_q != 2'd0) ? w0_q : ram_rdata;
    accept     = tx_valid_q && tx_ready;
    fin        = accept && tx_last_q;
    load       = streaming && head_ok && (!tx_valid_q || tx_ready) && (ld_idx_q < flen_q);
    pop        = load && (ld_idx_q[2:0] == 3'd7);
    push       = rd_pend_q;
    // Word 0 is requested in the start cycle so byte 0 can be registered out of FETCH.
    rd_fire    = start_ok ||
                 (streaming && (fw_q < nw_q) &&
                  (({1'b0, cnt_q} + {2'b00, rd_pend_q}) < 3'd2));
    rd_addr    = start_ok ? '0 : fw_q[WORD_AW-1:0];
    byte_d     = (ld_idx_q < len_q) ? head_w[{ld_idx_q[2:0], 3'b000} +: 8] : 8'h00;
    last_d     = (ld_idx_q == (flen_q - LEN_ONE));
  end

  // Two-entry word buffer bookkeeping: RAM data pushes, a fully sent word pops.
  always_comb begin
    cnt_d = cnt_q;
    w0_d  = w0_q;
    w1_d  = w1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          w0_d  = ram_rdata;
          cnt_d = 2'd1;
        end else begin
          w1_d  = ram_rdata;
          cnt_d = 2'd2;
        end
      end
      2'b01: begin
        w0_d  = w1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          w0_d = ram_rdata;
        end else if (cnt_q == 2'd2) begin
          w0_d = w1_q;
          w1_d = ram_rdata;
        end
      end
      default: ;
    endcase
  end

  // Word buffer storage; contents are only meaningful while cnt_q says so.
  always_ff @(posedge clk) begin
    w0_q <= w0_d;
    w1_q <= w1_d;
  end

  // Frame FSM, byte/word counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      len_q      <= '0;
      flen_q     <= '0;
      ld_idx_q   <= '0;
      fw_q       <= '0;
      nw_q       <= '0;
      rd_pend_q  <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      tx_done_q <= 1'b0;
      rd_pend_q <= rd_fire;
      cnt_q     <= cnt_d;
      if (rd_fire) begin
        fw_q <= fw_q + FW_ONE;
      end
      // Output only advances when empty or when the current byte is taken.
      if (load) begin
        ld_idx_q   <= ld_idx_q + LEN_ONE;
        tx_valid_q <= 1'b1;
        tx_data_q  <= byte_d;
        tx_last_q  <= last_d;
      end else if (accept) begin
        tx_valid_q <= 1'b0;
        tx_last_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q   <= FETCH;
            tx_busy_q <= 1'b1;
            len_q     <= tx_len;
            flen_q    <= flen_start;
            nw_q      <= nw_start;
            ld_idx_q  <= '0;
            fw_q      <= FW_ONE;
            cnt_q     <= 2'd0;
          end else if (start_zero) begin
            state_q   <= DONE;
            tx_done_q <= 1'b1;
          end
        end
        FETCH: state_q <= SEND;
        SEND: begin
          if (fin) begin
            state_q   <= DONE;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;

endmodule

// File: tb/tb_eth_tx_framebuf.sv
// Bench for eth_tx_framebuf: CPU port vectors from a table, directed frame
// sequences, and random frames/backpressure against a byte-array frame model.
module tb_eth_tx_framebuf;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic [7:0]  cpu_we;
  logic [7:0]  cpu_addr;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        tx_start;
  logic [10:0] tx_len;
  logic        tx_busy;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;

  int checks;
  int failures;

  // Model of buffer contents, byte-addressed: frame byte i is ref_mem[i].
  logic [7:0] ref_mem [2048];

  typedef struct {
    logic [7:0]  we;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic        chk;
    logic [63:0] exp;
  } cpu_vec_t;

  cpu_vec_t vecs [9];

  eth_tx_framebuf #(
    .WORD_AW (8),
    .LEN_W   (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .tx_start  (tx_start),
    .tx_len    (tx_len),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [63:0] data, input logic [7:0] we);
    cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    tick();
    cpu_en = 1'b0; cpu_we = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (we[k]) ref_mem[addr*8 + k] = data[8*k +: 8];
    end
  endtask

  task automatic load_inc(input int len);
    logic [63:0] w;
    for (int wi = 0; wi < (len + 7) / 8; wi++) begin
      for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((wi*8 + k) & 255);
      cpu_write(8'(wi), w, 8'hFF);
    end
  endtask

  task automatic load_rand(input int len);
    for (int wi = 0; wi < (len + 7) / 8; wi++) begin
      cpu_write(8'(wi), {$urandom, $urandom}, 8'hFF);
    end
  endtask

  // Starts a frame and checks every accepted byte against the model.
  task automatic run_frame(input int len, input bit rnd, input bit restart_mid);
    int flen;
    int idx;
    int cyc;
    int budget;
    bit stall;
    logic [7:0] sdata;
    logic slast;
    logic [7:0] exp_b;
    flen = (len < 60) ? 60 : len;
    idx = 0; cyc = 0; stall = 1'b0; sdata = 8'h00; slast = 1'b0;
    budget = 6 * flen + 100;
    tx_len = 11'(len); tx_start = 1'b1; tx_ready = 1'b1;
    tick();
    tx_start = 1'b0;
    check("start_busy", tx_busy, 1);
    check("start_valid", tx_valid, 0);
    while (idx < flen && cyc < budget) begin
      if (stall) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, sdata);
        check("stall_last", tx_last, slast);
      end
      if (!rnd && cyc >= 1) check("no_bubble", tx_valid, 1);
      if (restart_mid && idx == flen / 2) begin
        tx_start = 1'b1; tx_len = 11'd100;
      end else begin
        tx_start = 1'b0;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) begin
        exp_b = (idx < len) ? ref_mem[idx] : 8'h00;
        check($sformatf("byte%0d", idx), tx_data, exp_b);
        check($sformatf("last%0d", idx), tx_last, (idx == flen - 1) ? 1 : 0);
        idx++;
      end
      stall = tx_valid && !tx_ready;
      sdata = tx_data;
      slast = tx_last;
      tick();
      cyc++;
    end
    tx_start = 1'b0;
    check("frame_complete", idx, flen);
    if (!rnd) check("frame_cycles", cyc, flen + 1);
    check("done_pulse", tx_done, 1);
    check("end_valid", tx_valid, 0);
    check("end_busy", tx_busy, 0);
    tick();
    check("done_clear", tx_done, 0);
  endtask

  initial begin
    int idx;
    int cyc;
    int rlen;
    checks = 0; failures = 0;
    rst = 1'b1; cpu_en = 1'b0; cpu_we = 8'h00; cpu_addr = 8'h00; cpu_wdata = 64'h0;
    tx_start = 1'b0; tx_len = 11'd0; tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_last", tx_last, 0);
    check("rst_data", tx_data, 0);
    rst = 1'b0;
    tick();

    // Random background so pad bytes must come from the pad mux, not the RAM.
    for (int wi = 0; wi < 256; wi++) cpu_write(8'(wi), {$urandom, $urandom} | 64'h1, 8'hFF);

    // CPU port byte-lane vectors.
    vecs[0] = '{8'hFF, 8'd5, 64'h1122334455667788, 1'b0, 64'h0};
    vecs[1] = '{8'h00, 8'd5, 64'h0, 1'b1, 64'h1122334455667788};
    vecs[2] = '{8'h0F, 8'd5, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'h0};
    vecs[3] = '{8'h00, 8'd5, 64'h0, 1'b1, 64'h11223344AAAAAAAA};
    vecs[4] = '{8'h80, 8'd5, 64'h55FFFFFFFFFFFFFF, 1'b0, 64'h0};
    vecs[5] = '{8'h00, 8'd5, 64'h0, 1'b1, 64'h55223344AAAAAAAA};
    vecs[6] = '{8'hFF, 8'd6, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0};
    vecs[7] = '{8'h00, 8'd6, 64'h0, 1'b1, 64'hDEADBEEFCAFEF00D};
    vecs[8] = '{8'h00, 8'd5, 64'h0, 1'b1, 64'h55223344AAAAAAAA};
    for (int i = 0; i < 9; i++) begin
      cpu_write(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      if (vecs[i].chk) check($sformatf("cpu_vec%0d", i), cpu_rdata, vecs[i].exp);
    end

    // Short frame padded to 60 bytes.
    load_inc(16);
    check("word0", {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4], ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]}, 64'h0706050403020100);
    run_frame(16, 1'b0, 1'b0);

    // Long frame, continuous and with random backpressure.
    load_inc(1500);
    run_frame(1500, 1'b0, 1'b0);
    run_frame(1500, 1'b1, 1'b0);

    // Pad boundaries.
    load_rand(64);
    run_frame(59, 1'b0, 1'b0);
    run_frame(60, 1'b0, 1'b0);
    run_frame(61, 1'b1, 1'b0);

    // Start and length change mid-frame are ignored.
    load_rand(200);
    run_frame(200, 1'b0, 1'b1);

    // Zero-length start.
    tx_len = 11'd0; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("zero_done", tx_done, 1);
    check("zero_busy", tx_busy, 0);
    check("zero_valid", tx_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("zero_valid_after", tx_valid, 0);
      check("zero_done_after", tx_done, 0);
    end

    // Reset at byte 20 of a 200-byte frame, then a clean resend.
    tx_len = 11'd200; tx_start = 1'b1; tx_ready = 1'b1;
    tick();
    tx_start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 20 && cyc < 200) begin
      if (tx_valid) idx++;
      tick();
      cyc++;
    end
    check("rst20_reached", idx, 20);
    check("rst20_valid", tx_valid, 1);
    check("rst20_data", tx_data, ref_mem[20]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst20_valid_off", tx_valid, 0);
    check("rst20_busy_off", tx_busy, 0);
    check("rst20_no_done", tx_done, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst20_quiet_done", tx_done, 0);
      check("rst20_quiet_valid", tx_valid, 0);
    end
    run_frame(200, 1'b0, 1'b0);

    // Maximum-length frame covering every word address.
    load_rand(2047);
    run_frame(2047, 1'b0, 1'b0);

    // Random frames with random backpressure.
    for (int r = 0; r < 4; r++) begin
      rlen = $urandom_range(1, 400);
      load_rand(rlen);
      run_frame(rlen, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
